// File: rtl/debug_trace_buffer_if.sv
// debug_trace_buffer_if
//   Bundles the retirement-tap, control and read-port signals of
//   debug_trace_buffer. The master modport is the host/core side and the
//   slave modport is the trace buffer itself.
//   Record width grows by a 32-bit cycle stamp when the macro
//   DEBUG_TRACE_CYCLE_STAMP_EN is defined.
//   Signals:
//     valid_i, pc_i, inst_i, rdata1_i, rdata2_i, alu_i : retirement tap
//     arm_i, abort_i, trig_pc_i                        : capture control
//     rd_req_i, rd_idx_i, rd_valid_o, rd_data_o        : read port
//     state_o, count_o, triggered_o, done_o            : status
interface debug_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef DEBUG_TRACE_CYCLE_STAMP_EN
  localparam int REC_W = 4 * XLEN + 32 + 32;
`else
  localparam int REC_W = 4 * XLEN + 32;
`endif

  logic             valid_i;
  logic [XLEN-1:0]  pc_i;
  logic [31:0]      inst_i;
  logic [XLEN-1:0]  rdata1_i;
  logic [XLEN-1:0]  rdata2_i;
  logic [XLEN-1:0]  alu_i;
  logic             arm_i;
  logic             abort_i;
  logic [XLEN-1:0]  trig_pc_i;
  logic             rd_req_i;
  logic [PTR_W-1:0] rd_idx_i;
  logic             rd_valid_o;
  logic [REC_W-1:0] rd_data_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] count_o;
  logic             triggered_o;
  logic             done_o;

  modport master (
    output valid_i, pc_i, inst_i, rdata1_i, rdata2_i, alu_i,
    output arm_i, abort_i, trig_pc_i, rd_req_i, rd_idx_i,
    input  rd_valid_o, rd_data_o, state_o, count_o, triggered_o, done_o
  );

  modport slave (
    input  valid_i, pc_i, inst_i, rdata1_i, rdata2_i, alu_i,
    input  arm_i, abort_i, trig_pc_i, rd_req_i, rd_idx_i,
    output rd_valid_o, rd_data_o, state_o, count_o, triggered_o, done_o
  );
endinterface

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer
//   Retirement-trace capture unit. Records {pc, inst, rdata1, rdata2, alu}
//   into a DEPTH-slot circular buffer while armed, triggers on a PC match,
//   keeps POST_TRIG further records, then freezes. Records are read back
//   through a one-cycle-latency port, index 0 being the oldest record.
//   Optional feature macro: DEBUG_TRACE_CYCLE_STAMP_EN appends a 32-bit
//   free-running cycle stamp as the record LSBs.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-high reset, clears all control state
//     bus   : debug_trace_buffer_if slave modport (tap, control, read, status)
module debug_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input logic                 clk,
  input logic                 reset,
  debug_trace_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef DEBUG_TRACE_CYCLE_STAMP_EN
  localparam int REC_W = 4 * XLEN + 32 + 32;
`else
  localparam int REC_W = 4 * XLEN + 32;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] post_q;
  logic             trig_q;
  logic             done_q;
  logic             rd_valid_q;
  logic [REC_W-1:0] rd_data_q;
  logic [REC_W-1:0] mem_q [DEPTH];

  logic             wr_en;
  logic             pc_hit;
  logic             cnt_full;
  logic [REC_W-1:0] rec_d;
  logic [PTR_W-1:0] rd_slot;
  logic             rd_hit;

`ifdef DEBUG_TRACE_CYCLE_STAMP_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_q + 32'd1;
  end

  // The stamp is the counter value seen at the capture edge.
  assign rec_d = {bus.pc_i, bus.inst_i, bus.rdata1_i, bus.rdata2_i, bus.alu_i, cyc_q};
`else
  assign rec_d = {bus.pc_i, bus.inst_i, bus.rdata1_i, bus.rdata2_i, bus.alu_i};
`endif

  // abort and arm both pre-empt a capture in the same cycle.
  assign wr_en    = bus.valid_i && !bus.abort_i && !bus.arm_i &&
                    ((state_q == S_ARMED) || (state_q == S_POST));
  assign pc_hit   = (bus.pc_i == bus.trig_pc_i);
  assign cnt_full = (count_q == CNT_W'(DEPTH));
  // Oldest record sits count slots behind the write pointer; a full buffer
  // has count mod DEPTH == 0, so the oldest slot is the write pointer itself.
  assign rd_slot  = wr_ptr_q - count_q[PTR_W-1:0] + bus.rd_idx_i;
  assign rd_hit   = ({1'b0, bus.rd_idx_i} < count_q);

  // Control state machine
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
      trig_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.abort_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      post_q  <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.arm_i) begin
      state_q  <= S_ARMED;
      wr_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
      trig_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (!cnt_full) count_q <= count_q + CNT_W'(1);
      if (state_q == S_ARMED) begin
        if (pc_hit) begin
          trig_q <= 1'b1;
          if (POST_TRIG == 0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_POST;
            post_q  <= CNT_W'(POST_TRIG);
          end
        end
      end else begin
        // S_POST: PC matches are ignored, only the countdown matters.
        post_q <= post_q - CNT_W'(1);
        if (post_q == CNT_W'(1)) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  // Record storage, no reset: validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rec_d;
  end

  // Read port: registered, returns pre-write contents on a same-slot write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (bus.rd_req_i) begin
      rd_valid_q <= rd_hit;
      rd_data_q  <= rd_hit ? mem_q[rd_slot] : '0;
    end
  end

  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.state_o     = state_q;
  assign bus.count_o     = count_q;
  assign bus.triggered_o = trig_q;
  assign bus.done_o      = done_q;
endmodule

// File: tb/tb_debug_trace_buffer.sv
module tb_debug_trace_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
`ifdef DEBUG_TRACE_CYCLE_STAMP_EN
  localparam int STAMP_W = 32;
`else
  localparam int STAMP_W = 0;
`endif
  localparam int REC_W = 4 * XLEN + 32 + STAMP_W;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   tot_cnt;

  debug_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus0 ();
  debug_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus1 ();

  debug_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(2)) u_dut0 (
    .clk(clk), .reset(rst), .bus(bus0.slave)
  );
  debug_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(0)) u_dut1 (
    .clk(clk), .reset(rst), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc);
    bus0.valid_i  = 1'b1;
    bus0.pc_i     = pc;
    bus0.inst_i   = pc | 32'h0000_0013;
    bus0.rdata1_i = pc + 32'd1;
    bus0.rdata2_i = pc + 32'd2;
    bus0.alu_i    = pc + 32'd3;
    step();
    bus0.valid_i  = 1'b0;
  endtask

  task automatic arm();
    bus0.arm_i = 1'b1;
    step();
    bus0.arm_i = 1'b0;
  endtask

  task automatic rd(input int idx);
    bus0.rd_req_i = 1'b1;
    bus0.rd_idx_i = 3'(idx);
    step();
    bus0.rd_req_i = 1'b0;
  endtask

  task automatic test_reset();
    tot_cnt++; if (bus0.state_o !== 2'd0) $display("FAIL rst_state got=%0d exp=0", bus0.state_o); else pass_cnt++;
    tot_cnt++; if (bus0.count_o !== 4'd0) $display("FAIL rst_count got=%0d exp=0", bus0.count_o); else pass_cnt++;
    tot_cnt++; if (bus0.triggered_o !== 1'b0 || bus0.done_o !== 1'b0)
      $display("FAIL rst_flags got=%b%b exp=00", bus0.triggered_o, bus0.done_o); else pass_cnt++;
    tot_cnt++; if (bus0.rd_valid_o !== 1'b0 || bus0.rd_data_o !== '0)
      $display("FAIL rst_rd got=%b/%h exp=0/0", bus0.rd_valid_o, bus0.rd_data_o); else pass_cnt++;
  endtask

  task automatic run_basic(input string tag);
    bus0.trig_pc_i = 32'h08;
    arm();
    retire(32'h00); retire(32'h04); retire(32'h08);
    tot_cnt++; if (bus0.state_o !== 2'd2 || bus0.triggered_o !== 1'b1)
      $display("FAIL %s_post got=%0d/%b exp=2/1", tag, bus0.state_o, bus0.triggered_o); else pass_cnt++;
    retire(32'h0C); retire(32'h10);
    tot_cnt++; if (bus0.state_o !== 2'd3 || bus0.done_o !== 1'b1)
      $display("FAIL %s_done got=%0d/%b exp=3/1", tag, bus0.state_o, bus0.done_o); else pass_cnt++;
    tot_cnt++; if (bus0.count_o !== 4'd5) $display("FAIL %s_count got=%0d exp=5", tag, bus0.count_o); else pass_cnt++;
    rd(0);
    tot_cnt++; if (bus0.rd_valid_o !== 1'b1 || bus0.rd_data_o[REC_W-1 -: 32] !== 32'h00)
      $display("FAIL %s_rd0 got=%b/%h exp=1/00000000", tag, bus0.rd_valid_o, bus0.rd_data_o[REC_W-1 -: 32]); else pass_cnt++;
    rd(2);
    tot_cnt++; if (bus0.rd_data_o[REC_W-33 -: 32] !== 32'h1B || bus0.rd_data_o[STAMP_W +: 32] !== 32'h0B)
      $display("FAIL %s_rd2 got=%h/%h exp=0000001b/0000000b", tag,
               bus0.rd_data_o[REC_W-33 -: 32], bus0.rd_data_o[STAMP_W +: 32]); else pass_cnt++;
    rd(4);
    tot_cnt++; if (bus0.rd_valid_o !== 1'b1 || bus0.rd_data_o[REC_W-1 -: 32] !== 32'h10)
      $display("FAIL %s_rd4 got=%b/%h exp=1/00000010", tag, bus0.rd_valid_o, bus0.rd_data_o[REC_W-1 -: 32]); else pass_cnt++;
    rd(5);
    tot_cnt++; if (bus0.rd_valid_o !== 1'b0 || bus0.rd_data_o !== '0)
      $display("FAIL %s_rd5 got=%b/%h exp=0/0", tag, bus0.rd_valid_o, bus0.rd_data_o); else pass_cnt++;
  endtask

  task automatic test_basic();
    run_basic("basic");
  endtask

  task automatic test_wrap();
    bus0.trig_pc_i = 32'h2C;
    arm();
    for (int i = 0; i < 12; i++) retire(32'(i * 4));
    retire(32'h30); retire(32'h34);
    tot_cnt++; if (bus0.state_o !== 2'd3 || bus0.count_o !== 4'd8)
      $display("FAIL wrap_done got=%0d/%0d exp=3/8", bus0.state_o, bus0.count_o); else pass_cnt++;
    rd(0);
    tot_cnt++; if (bus0.rd_data_o[REC_W-1 -: 32] !== 32'h18)
      $display("FAIL wrap_rd0 got=%h exp=00000018", bus0.rd_data_o[REC_W-1 -: 32]); else pass_cnt++;
    rd(7);
    tot_cnt++; if (bus0.rd_data_o[REC_W-1 -: 32] !== 32'h34)
      $display("FAIL wrap_rd7 got=%h exp=00000034", bus0.rd_data_o[REC_W-1 -: 32]); else pass_cnt++;
    retire(32'h38); retire(32'h3C);
    tot_cnt++; if (bus0.count_o !== 4'd8 || bus0.state_o !== 2'd3)
      $display("FAIL wrap_frozen got=%0d/%0d exp=8/3", bus0.count_o, bus0.state_o); else pass_cnt++;
    rd(7);
    tot_cnt++; if (bus0.rd_data_o[REC_W-1 -: 32] !== 32'h34)
      $display("FAIL wrap_rd7b got=%h exp=00000034", bus0.rd_data_o[REC_W-1 -: 32]); else pass_cnt++;
    rd(0);
    tot_cnt++; if (bus0.rd_data_o[REC_W-1 -: 32] !== 32'h18)
      $display("FAIL wrap_rd0b got=%h exp=00000018", bus0.rd_data_o[REC_W-1 -: 32]); else pass_cnt++;
  endtask

  task automatic test_valid_low();
    bus0.trig_pc_i = 32'h40;
    arm();
    retire(32'h3C);
    bus0.valid_i = 1'b0;
    bus0.pc_i    = 32'h40;
    step(); step(); step();
    tot_cnt++; if (bus0.state_o !== 2'd1 || bus0.count_o !== 4'd1 || bus0.triggered_o !== 1'b0)
      $display("FAIL vlow_hold got=%0d/%0d/%b exp=1/1/0", bus0.state_o, bus0.count_o, bus0.triggered_o); else pass_cnt++;
    retire(32'h40);
    tot_cnt++; if (bus0.state_o !== 2'd2 || bus0.count_o !== 4'd2 || bus0.triggered_o !== 1'b1)
      $display("FAIL vlow_trig got=%0d/%0d/%b exp=2/2/1", bus0.state_o, bus0.count_o, bus0.triggered_o); else pass_cnt++;
  endtask

  task automatic test_abort_arm();
    bus0.trig_pc_i = 32'hFFFF_FFF0;
    arm();
    retire(32'h200); retire(32'h204);
    tot_cnt++; if (bus0.count_o !== 4'd2 || bus0.state_o !== 2'd1)
      $display("FAIL abort_pre got=%0d/%0d exp=2/1", bus0.count_o, bus0.state_o); else pass_cnt++;
    bus0.abort_i = 1'b1;
    bus0.arm_i   = 1'b1;
    bus0.valid_i = 1'b1;
    step();
    bus0.abort_i = 1'b0;
    bus0.arm_i   = 1'b0;
    bus0.valid_i = 1'b0;
    tot_cnt++; if (bus0.state_o !== 2'd0 || bus0.count_o !== 4'd0)
      $display("FAIL abort_arm got=%0d/%0d exp=0/0", bus0.state_o, bus0.count_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus0.trig_pc_i = 32'h14;
    arm();
    for (int i = 0; i < 6; i++) retire(32'(i * 4));
    tot_cnt++; if (bus0.state_o !== 2'd2 || bus0.count_o !== 4'd6)
      $display("FAIL rmid_pre got=%0d/%0d exp=2/6", bus0.state_o, bus0.count_o); else pass_cnt++;
    rd(0);
    tot_cnt++; if (bus0.rd_valid_o !== 1'b1)
      $display("FAIL rmid_rdv got=%b exp=1", bus0.rd_valid_o); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    tot_cnt++; if (bus0.state_o !== 2'd0 || bus0.count_o !== 4'd0 || bus0.triggered_o !== 1'b0 ||
                   bus0.done_o !== 1'b0 || bus0.rd_valid_o !== 1'b0 || bus0.rd_data_o !== '0)
      $display("FAIL rmid_async got=%0d/%0d/%b/%b/%b exp=0/0/0/0/0", bus0.state_o, bus0.count_o,
               bus0.triggered_o, bus0.done_o, bus0.rd_valid_o); else pass_cnt++;
    step();
    #2 rst = 1'b0;
    retire(32'h08);
    tot_cnt++; if (bus0.state_o !== 2'd0 || bus0.count_o !== 4'd0)
      $display("FAIL rmid_noarm got=%0d/%0d exp=0/0", bus0.state_o, bus0.count_o); else pass_cnt++;
    run_basic("rearm");
  endtask

  task automatic test_post0();
    bus1.trig_pc_i = 32'h100;
    bus1.arm_i = 1'b1;
    step();
    bus1.arm_i   = 1'b0;
    bus1.valid_i = 1'b1;
    bus1.pc_i    = 32'h100;
    step();
    bus1.valid_i = 1'b0;
    tot_cnt++; if (bus1.state_o !== 2'd3 || bus1.count_o !== 4'd1 || bus1.done_o !== 1'b1)
      $display("FAIL post0 got=%0d/%0d/%b exp=3/1/1", bus1.state_o, bus1.count_o, bus1.done_o); else pass_cnt++;
  endtask

  task automatic test_stamp();
`ifdef DEBUG_TRACE_CYCLE_STAMP_EN
    logic [31:0] base;
    bus0.trig_pc_i = 32'hFFFF_FFF0;
    arm();
    for (int i = 0; i < 5; i++) retire(32'h300 + 32'(i * 4));
    rd(0);
    base = bus0.rd_data_o[31:0];
    for (int i = 1; i < 5; i++) begin
      rd(i);
      tot_cnt++; if (bus0.rd_data_o[31:0] !== base + 32'(i))
        $display("FAIL stamp%0d got=%h exp=%h", i, bus0.rd_data_o[31:0], base + 32'(i)); else pass_cnt++;
    end
`endif
  endtask

  initial begin
    pass_cnt = 0;
    tot_cnt  = 0;
    rst = 1'b1;
    bus0.valid_i = 1'b0; bus0.pc_i = '0; bus0.inst_i = '0; bus0.rdata1_i = '0;
    bus0.rdata2_i = '0; bus0.alu_i = '0; bus0.arm_i = 1'b0; bus0.abort_i = 1'b0;
    bus0.trig_pc_i = '0; bus0.rd_req_i = 1'b0; bus0.rd_idx_i = '0;
    bus1.valid_i = 1'b0; bus1.pc_i = '0; bus1.inst_i = '0; bus1.rdata1_i = '0;
    bus1.rdata2_i = '0; bus1.alu_i = '0; bus1.arm_i = 1'b0; bus1.abort_i = 1'b0;
    bus1.trig_pc_i = '0; bus1.rd_req_i = 1'b0; bus1.rd_idx_i = '0;
    #3;
    test_reset();
    step(); step();
    #2 rst = 1'b0;
    step();
    test_basic();
    test_wrap();
    test_valid_low();
    test_abort_arm();
    test_reset_mid();
    test_post0();
    test_stamp();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
